bcd_key_encoder: RTL

//   Reverse of the BCD line decoder: turns 11 one-hot key/select lines D[10:0]

---
 rtl/bcd_key_encoder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bcd_key_encoder.sv
// ---------------------------------------------------------------------------
// bcd_key_encoder
//   Turns 11 one-hot key/select lines back into a 4-bit code 0..10.
//   The asynchronous lines pass through a 2-flop synchroniser. A key is
//   accepted after DB_CYC identical synchronised samples. Multi-key input is
//   rejected with a one-cycle ERR pulse. The accepted code is then held under
//   a VALID/ACK handshake. A held key cannot re-trigger until the lines have
//   read zero for DB_CYC synchronised cycles.
//
// Ports
//   CLK    in   1   clock, all flops rising-edge
//   RST    in   1   synchronous reset, active-high
//   D      in   11  asynchronous key lines, D[k]=1 means key k pressed
//   ACK    in   1   consumer accepts B; only looked at while VALID=1
//   B      out  4   last accepted code (0 after reset)
//   VALID  out  1   B holds an accepted, not yet acknowledged code
//   ERR    out  1   one-cycle pulse on multi-key input
// ---------------------------------------------------------------------------
module bcd_key_encoder #(
    parameter int DB_CYC = 4,
    parameter int CNT_W  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [10:0] D,
    input  logic        ACK,
    output logic [3:0]  B,
    output logic        VALID,
    output logic        ERR
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    logic [10:0]       r_s1;
    logic [10:0]       r_s2;
    logic [10:0]       r_p;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_b;
    logic              r_valid;
    logic              r_err;

    logic              w_zero;
    logic              w_multi;
    logic [3:0]        w_code;

    // Clearing the lowest set bit leaves something only when two or more
    // bits were set.
    assign w_zero  = (r_s2 == 11'd0);
    assign w_multi = ((r_s2 & (r_s2 - 11'd1)) != 11'd0);

    // r_p is one-hot by construction, so a priority scan is an exact encode.
    always_comb begin
        w_code = 4'd0;
        for (int k = 0; k < 11; k++) begin
            if (r_p[k]) w_code = 4'(k);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1    <= 11'd0;
            r_s2    <= 11'd0;
            r_p     <= 11'd0;
            r_cnt   <= '0;
            r_b     <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_s1  <= D;
            r_s2  <= r_s1;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_multi) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end else if (!w_zero) begin
                        r_p     <= r_s2;
                        r_cnt   <= CNT_ONE;
                        r_state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (r_s2 == r_p) begin
                        if (r_cnt == CNT_LAST) begin
                            r_b     <= w_code;
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else if (w_multi) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end else begin
                        // Changed or dropped key: restart quietly from IDLE.
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    // Line activity is ignored here; only ACK leaves HOLD.
                    if (ACK) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Need DB_CYC consecutive zero samples before re-arming.
                    if (w_zero) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign B     = r_b;
    assign VALID = r_valid;
    assign ERR   = r_err;

endmodule
